// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT matrix-multiply stages (T-compute and S-compute).
package idct_pkg;

  // Sequencer states of a matrix-multiply stage.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEAD_IN = 3'd1,
    S_ACC     = 3'd2,
    S_W0      = 3'd3,
    S_W1      = 3'd4,
    S_W2      = 3'd5,
    S_END     = 3'd6
  } state_e;

  // Block sizes: luma blocks are 16x16, chroma blocks 8x8.
  localparam int N_Y  = 16;
  localparam int N_UV = 8;

  // Column groups per row: three columns per group, last group partially used.
  localparam int G_Y  = 6;
  localparam int G_UV = 3;

  // Base of each coefficient matrix inside the C DPRAM.
  localparam logic [7:0] C_BASE_Y  = 8'h00;
  localparam logic [7:0] C_BASE_UV = 8'h80;

  // Fixed-point scaling applied to each finished dot product.
  localparam int T_SHIFT = 8;

  // Sign-extend a 16-bit signed RAM half-word to 32 bits.
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/coeff_triple_select.sv
// Picks three consecutive C matrix elements out of two adjacent packed C words
// and sign-extends them into the three multiplier lane operands.
module coeff_triple_select
  import idct_pkg::*;
(
  input  logic [31:0]      c_a_i,
  input  logic [31:0]      c_b_i,
  input  logic             odd_i,
  output logic [2:0][31:0] op_o
);

  // Even first column starts at the high half of word a; odd starts at its low half.
  always_comb begin
    op_o = '0;
    if (odd_i) begin
      op_o[0] = sext16(c_a_i[15:0]);
      op_o[1] = sext16(c_b_i[31:16]);
      op_o[2] = sext16(c_b_i[15:0]);
    end else begin
      op_o[0] = sext16(c_a_i[31:16]);
      op_o[1] = sext16(c_a_i[15:0]);
      op_o[2] = sext16(c_b_i[31:16]);
    end
  end

endmodule

// File: rtl/compute_t.sv
// First IDCT matrix multiply: T = (S' * C) >>> 8, three output columns per pass
// through the shared three-lane multiplier, results written to the T DPRAM.
module compute_t
  import idct_pkg::*;
(
  input  logic               Clock_50,
  input  logic               Reset,
  input  logic               start,
  input  logic               Y_finished,
  output logic               done,
  output logic [7:0]         Address_Sp_a,
  input  logic [31:0]        Data_out_Sp_a,
  output logic [7:0]         Address_C_a,
  output logic [7:0]         Address_C_b,
  input  logic [31:0]        Data_out_C_a,
  input  logic [31:0]        Data_out_C_b,
  output logic [7:0]         T_DP_RAM_address_a,
  output logic               Write_en_T_a,
  output logic [31:0]        T_DP_RAM_write_data_a,
  output logic signed [31:0] mult_op1_a,
  output logic signed [31:0] mult_op1_b,
  output logic signed [31:0] mult_op1_c,
  output logic signed [31:0] mult_op2_a,
  output logic signed [31:0] mult_op2_b,
  output logic signed [31:0] mult_op2_c,
  input  logic signed [31:0] mult_result_a,
  input  logic signed [31:0] mult_result_b,
  input  logic signed [31:0] mult_result_c
);

  state_e           state_q;
  logic             uv_q;        // 1: 8x8 chroma block, 0: 16x16 luma block
  logic [3:0]       a_q;         // output row
  logic [2:0]       g_q;         // column group
  logic [4:0]       j_q;         // j whose addresses are being presented
  logic [4:0]       jd_q;        // j of the RAM data arriving this cycle
  logic [2:0][31:0] acc_q, acc_d;
  logic [7:0]       sp_addr_q, ca_addr_q, cb_addr_q, t_addr_q;
  logic             wr_en_q, done_q;
  logic [31:0]      wr_data_q;

  // S' word address: row a holds N/2 packed words, two j per word.
  function automatic logic [7:0] sp_addr_f(input logic uv, input logic [3:0] a,
                                           input logic [4:0] j);
    logic [7:0] row;
    row = uv ? {2'b00, a, 2'b00} : {1'b0, a, 3'b000};
    return row + 8'(j >> 1);
  endfunction

  // C word address of the first of three columns 3g..3g+2 in row j.
  function automatic logic [7:0] c_addr_f(input logic uv, input logic [2:0] g,
                                          input logic [4:0] j);
    logic [7:0] col0, row;
    col0 = {5'b0, g} + {4'b0, g, 1'b0};
    row  = uv ? {1'b0, j, 2'b00} : {j, 3'b000};
    return (uv ? C_BASE_UV : C_BASE_Y) + row + (col0 >> 1);
  endfunction

  // Mode-dependent sizes and current write geometry.
  logic [4:0]       n_cur;
  logic [2:0]       g_last;
  logic [7:0]       col0, row_base;
  logic             in_acc, g_wrap, a_last;
  logic [3:0]       a_nx;
  logic [2:0]       g_nx;
  logic [4:0]       j_inc;
  logic [2:0][31:0] c_ops, prod, t_val;
  logic [2:0][7:0]  lane_col;
  logic [2:0]       lane_ok;
  logic [15:0]      sp_half;
  logic [31:0]      sp_ext;

  assign n_cur    = uv_q ? 5'(N_UV) : 5'(N_Y);
  assign g_last   = uv_q ? 3'(G_UV - 1) : 3'(G_Y - 1);
  assign col0     = {5'b0, g_q} + {4'b0, g_q, 1'b0};
  assign row_base = uv_q ? {1'b0, a_q, 3'b000} : {a_q, 4'b0000};
  assign in_acc   = (state_q == S_ACC);
  assign g_wrap   = (g_q == g_last);
  assign a_last   = ({1'b0, a_q} == n_cur - 5'd1);
  assign a_nx     = g_wrap ? a_q + 4'd1 : a_q;
  assign g_nx     = g_wrap ? 3'd0 : g_q + 3'd1;
  assign j_inc    = j_q + 5'd1;

  // S' half for the returning word is chosen by the registered j.
  assign sp_half = jd_q[0] ? Data_out_Sp_a[15:0] : Data_out_Sp_a[31:16];
  assign sp_ext  = sext16(sp_half);

  coeff_triple_select u_sel (
    .c_a_i (Data_out_C_a),
    .c_b_i (Data_out_C_b),
    .odd_i (g_q[0]),       // 3g is odd exactly when g is odd
    .op_o  (c_ops)
  );

  // Operands are only driven while accumulating; idle lanes see zero.
  assign mult_op1_a = in_acc ? c_ops[0] : '0;
  assign mult_op1_b = in_acc ? c_ops[1] : '0;
  assign mult_op1_c = in_acc ? c_ops[2] : '0;
  assign mult_op2_a = in_acc ? sp_ext : '0;
  assign mult_op2_b = in_acc ? sp_ext : '0;
  assign mult_op2_c = in_acc ? sp_ext : '0;

  assign prod[0] = mult_result_a;
  assign prod[1] = mult_result_b;
  assign prod[2] = mult_result_c;

  // Accumulate: first j of a group loads, later j add; 32-bit wrap.
  always_comb begin
    acc_d = acc_q;
    if (in_acc) begin
      for (int l = 0; l < 3; l++)
        acc_d[l] = (jd_q == 5'd0) ? prod[l] : acc_q[l] + prod[l];
    end
  end

  // Per-lane write column, validity and scaled result.
  always_comb begin
    lane_col = '0;
    lane_ok  = '0;
    t_val    = '0;
    for (int l = 0; l < 3; l++) begin
      lane_col[l] = col0 + 8'(l);
      lane_ok[l]  = (lane_col[l] < {3'b000, n_cur});
      t_val[l]    = 32'($signed(acc_d[l]) >>> T_SHIFT);
    end
  end

  // Sequencer: address generation, accumulators and registered T writes.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      uv_q      <= 1'b0;
      a_q       <= '0;
      g_q       <= '0;
      j_q       <= '0;
      jd_q      <= '0;
      acc_q     <= '0;
      sp_addr_q <= '0;
      ca_addr_q <= '0;
      cb_addr_q <= '0;
      t_addr_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      acc_q   <= acc_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            uv_q      <= Y_finished;
            a_q       <= '0;
            g_q       <= '0;
            j_q       <= '0;
            jd_q      <= '0;
            sp_addr_q <= sp_addr_f(Y_finished, 4'd0, 5'd0);
            ca_addr_q <= c_addr_f(Y_finished, 3'd0, 5'd0);
            cb_addr_q <= c_addr_f(Y_finished, 3'd0, 5'd0) + 8'd1;
            state_q   <= S_LEAD_IN;
          end
        end
        S_LEAD_IN, S_ACC: begin
          if (state_q == S_ACC && j_q == n_cur) begin
            // Last product lands this cycle; lane 0 writes straight from acc_d.
            wr_en_q   <= lane_ok[0];
            t_addr_q  <= row_base + lane_col[0];
            wr_data_q <= t_val[0];
            state_q   <= S_W0;
          end else begin
            jd_q      <= j_q;
            j_q       <= j_inc;
            sp_addr_q <= sp_addr_f(uv_q, a_q, j_inc);
            ca_addr_q <= c_addr_f(uv_q, g_q, j_inc);
            cb_addr_q <= c_addr_f(uv_q, g_q, j_inc) + 8'd1;
            state_q   <= S_ACC;
          end
        end
        S_W0: begin
          wr_en_q   <= lane_ok[1];
          t_addr_q  <= row_base + lane_col[1];
          wr_data_q <= t_val[1];
          state_q   <= S_W1;
        end
        S_W1: begin
          wr_en_q   <= lane_ok[2];
          t_addr_q  <= row_base + lane_col[2];
          wr_data_q <= t_val[2];
          state_q   <= S_W2;
        end
        S_W2: begin
          j_q  <= '0;
          jd_q <= '0;
          if (g_wrap && a_last) begin
            sp_addr_q <= '0;
            ca_addr_q <= '0;
            cb_addr_q <= '0;
            t_addr_q  <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b1;
            state_q   <= S_END;
          end else begin
            a_q       <= a_nx;
            g_q       <= g_nx;
            sp_addr_q <= sp_addr_f(uv_q, a_nx, 5'd0);
            ca_addr_q <= c_addr_f(uv_q, g_nx, 5'd0);
            cb_addr_q <= c_addr_f(uv_q, g_nx, 5'd0) + 8'd1;
            state_q   <= S_LEAD_IN;
          end
        end
        S_END: begin
          a_q     <= '0;
          g_q     <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done                  = done_q;
  assign Address_Sp_a          = sp_addr_q;
  assign Address_C_a           = ca_addr_q;
  assign Address_C_b           = cb_addr_q;
  assign T_DP_RAM_address_a    = t_addr_q;
  assign Write_en_T_a          = wr_en_q;
  assign T_DP_RAM_write_data_a = wr_data_q;

endmodule

// File: tb/tb_compute_t.sv
// Directed bench for compute_t: RAM and multiplier models, hand-derived results.
module tb_compute_t;

  logic               clk = 1'b0;
  logic               Reset, start, Y_finished, done;
  logic [7:0]         Address_Sp_a, Address_C_a, Address_C_b, T_DP_RAM_address_a;
  logic [31:0]        Data_out_Sp_a, Data_out_C_a, Data_out_C_b, T_DP_RAM_write_data_a;
  logic               Write_en_T_a;
  logic signed [31:0] mult_op1_a, mult_op1_b, mult_op1_c;
  logic signed [31:0] mult_op2_a, mult_op2_b, mult_op2_c;
  logic signed [31:0] mult_result_a, mult_result_b, mult_result_c;

  always #5 clk = ~clk;

  compute_t dut (
    .Clock_50(clk), .Reset(Reset), .start(start), .Y_finished(Y_finished), .done(done),
    .Address_Sp_a(Address_Sp_a), .Data_out_Sp_a(Data_out_Sp_a),
    .Address_C_a(Address_C_a), .Address_C_b(Address_C_b),
    .Data_out_C_a(Data_out_C_a), .Data_out_C_b(Data_out_C_b),
    .T_DP_RAM_address_a(T_DP_RAM_address_a), .Write_en_T_a(Write_en_T_a),
    .T_DP_RAM_write_data_a(T_DP_RAM_write_data_a),
    .mult_op1_a(mult_op1_a), .mult_op1_b(mult_op1_b), .mult_op1_c(mult_op1_c),
    .mult_op2_a(mult_op2_a), .mult_op2_b(mult_op2_b), .mult_op2_c(mult_op2_c),
    .mult_result_a(mult_result_a), .mult_result_b(mult_result_b), .mult_result_c(mult_result_c)
  );

  // Combinational multiplier, low 32 bits.
  assign mult_result_a = mult_op1_a * mult_op2_a;
  assign mult_result_b = mult_op1_b * mult_op2_b;
  assign mult_result_c = mult_op1_c * mult_op2_c;

  logic [31:0] sp_mem [256];
  logic [31:0] c_mem  [256];
  logic [31:0] t_mem  [256];
  int          wr_ep  [256];
  int          cur_ep;
  int          wr_cnt = 0;
  logic [7:0]  last_wa = '0;
  int          passed = 0, total = 0;

  // Synchronous-read DPRAMs.
  always @(posedge clk) begin
    Data_out_Sp_a <= sp_mem[Address_Sp_a];
    Data_out_C_a  <= c_mem[Address_C_a];
    Data_out_C_b  <= c_mem[Address_C_b];
  end

  // T DPRAM capture; each write is stamped with the current run epoch.
  always @(posedge clk) begin
    if (Write_en_T_a === 1'b1) begin
      t_mem[T_DP_RAM_address_a] = T_DP_RAM_write_data_a;
      wr_ep[T_DP_RAM_address_a] = cur_ep;
      wr_cnt  = wr_cnt + 1;
      last_wa = T_DP_RAM_address_a;
    end
  end

  function automatic logic outs_nonzero();
    return |{done, Address_Sp_a, Address_C_a, Address_C_b, T_DP_RAM_address_a,
             Write_en_T_a, T_DP_RAM_write_data_a, mult_op1_a, mult_op1_b, mult_op1_c,
             mult_op2_a, mult_op2_b, mult_op2_c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, expv);
  endtask

  // kind 0: impulse, 1: ramp, 2: negative truncation.
  function automatic logic [31:0] exp_t(input int kind, input int a, input int b);
    case (kind)
      0:       return (a == 0) ? 32'd1 : 32'd0;
      1:       return 32'(16 * b);
      default: return (a == 0 && b == 0) ? 32'hFFFF_FFFE : 32'd0;
    endcase
  endfunction

  task automatic load(input int kind);
    for (int i = 0; i < 256; i++) begin
      sp_mem[i] = '0;
      c_mem[i]  = '0;
    end
    case (kind)
      0: begin
        sp_mem[0] = {16'd256, 16'd0};
        for (int i = 0; i < 256; i++) c_mem[i] = {16'd1, 16'd1};
      end
      1: begin
        for (int i = 0; i < 128; i++) sp_mem[i] = {16'd256, 16'd256};
        for (int j = 0; j < 16; j++)
          for (int k = 0; k < 8; k++) c_mem[j*8+k] = {16'(2*k), 16'(2*k+1)};
      end
      default: begin
        sp_mem[0]    = {16'hFED4, 16'h0000};   // -300 at S'[0][0]
        c_mem[8'h80] = {16'd1, 16'd0};         // C[0][0] = 1 in the 8x8 area
      end
    endcase
  endtask

  task automatic t_errs(input int kind, input int n, output int errs);
    errs = 0;
    for (int a = 0; a < n; a++)
      for (int b = 0; b < n; b++)
        if (wr_ep[a*n+b] != cur_ep || t_mem[a*n+b] !== exp_t(kind, a, b)) errs++;
  endtask

  // Starts one block. lat counts the start-sampling edge as cycle 1 and is the
  // cycle in which done is seen; -1 on reset abort or timeout.
  task automatic run(input logic yf, input bit tog, input int busy_cyc, input int rst_cyc,
                     output int lat);
    int cyc;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    Y_finished = yf;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 4000) begin
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
      if (tog && (cyc % 7 == 0)) Y_finished = ~Y_finished;
      start = (cyc == busy_cyc);
      if (cyc == rst_cyc) begin
        Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        break;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, errs, base, nz;
    for (int i = 0; i < 256; i++) begin
      t_mem[i] = '0;
      wr_ep[i] = -1;
    end
    cur_ep = 0;
    Reset = 1'b1; start = 1'b0; Y_finished = 1'b0;
    load(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs_zero", 32'(outs_nonzero()), 0);
    Reset = 1'b0;
    base = wr_cnt; nz = 0;
    repeat (50) begin
      @(posedge clk); @(negedge clk);
      if (outs_nonzero()) nz++;
    end
    chk("reset_quiet_writes", wr_cnt - base, 0);
    chk("reset_quiet_outs", nz, 0);

    // N=8 impulse
    load(0); cur_ep = 1; base = wr_cnt;
    run(1'b1, 0, 0, 0, lat);
    chk("impulse_latency", lat, 289);
    chk("impulse_writes", wr_cnt - base, 64);
    t_errs(0, 8, errs);
    chk("impulse_T", errs, 0);

    // N=16 ramp
    load(1); cur_ep = 2; base = wr_cnt;
    run(1'b0, 0, 0, 0, lat);
    chk("ramp_latency", lat, 1921);
    chk("ramp_writes", wr_cnt - base, 256);
    chk("ramp_last_addr", {24'b0, last_wa}, 255);
    t_errs(1, 16, errs);
    chk("ramp_T", errs, 0);

    // Negative truncation
    load(2); cur_ep = 3;
    run(1'b1, 0, 0, 0, lat);
    chk("neg_latency", lat, 289);
    chk("neg_T00", t_mem[0], 32'hFFFF_FFFE);
    t_errs(2, 8, errs);
    chk("neg_T", errs, 0);

    // start while busy (cycle 40) and in the S_END cycle is ignored
    load(0); cur_ep = 4; base = wr_cnt;
    run(1'b1, 0, 40, 0, lat);
    chk("busy_latency", lat, 289);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    nz = 0;
    repeat (30) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1 || Address_Sp_a != 0) nz++;
    end
    chk("busy_writes", wr_cnt - base, 64);
    chk("busy_no_restart", nz, 0);
    t_errs(0, 8, errs);
    chk("busy_T", errs, 0);

    // Reset mid-run, then a clean restart
    cur_ep = 5;
    run(1'b1, 0, 0, 100, lat);
    chk("midrst_wr_en", {31'b0, Write_en_T_a}, 0);
    chk("midrst_outs_zero", 32'(outs_nonzero()), 0);
    Reset = 1'b0;
    base = wr_cnt;
    repeat (20) begin @(posedge clk); @(negedge clk); end
    chk("midrst_quiet", wr_cnt - base, 0);
    cur_ep = 6; base = wr_cnt;
    run(1'b1, 0, 0, 0, lat);
    chk("restart_latency", lat, 289);
    chk("restart_writes", wr_cnt - base, 64);
    t_errs(0, 8, errs);
    chk("restart_T", errs, 0);

    // Mode latched at start: Y_finished toggling mid-run has no effect
    load(1); cur_ep = 7; base = wr_cnt;
    run(1'b0, 1, 0, 0, lat);
    Y_finished = 1'b0;
    chk("mode_latency", lat, 1921);
    chk("mode_writes", wr_cnt - base, 256);
    chk("mode_last_addr", {24'b0, last_wa}, 255);
    t_errs(1, 16, errs);
    chk("mode_T", errs, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
